// File: rtl/mem_access_ctrl.sv
// Clocked master between the CPU datapath and the 512x8 byte-addressed RAM (Enable/ReadWrite/MOC).
// Optional alignment fault checking is enabled by defining ALIGN_CHECK_EN.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter int unsigned ADDR_LIMIT     = 512
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Load,
    input  logic [1:0]  Size,
    input  logic        Signed,
    input  logic [31:0] Addr,
    input  logic [31:0] StoreData,
    output logic        Busy,
    output logic        Done,
    output logic        Err,
    output logic [31:0] LoadData,
    output logic        MemEnable,
    output logic        MemReadWrite,
    output logic [31:0] MemAddress,
    output logic [31:0] MemDataIn,
    output logic [5:0]  MemOP,
    input  logic [31:0] MemDataOut,
    input  logic        MOC
);

    localparam logic [7:0]  TimeoutCnt = 8'(TIMEOUT_CYCLES);
    localparam logic [32:0] AddrLimit  = 33'(ADDR_LIMIT);

    localparam logic [5:0] OpReadWord  = 6'b001000;
    localparam logic [5:0] OpReadHalf  = 6'b000010;
    localparam logic [5:0] OpReadByte  = 6'b000001;
    localparam logic [5:0] OpWriteWord = 6'b000100;
    localparam logic [5:0] OpWriteHalf = 6'b000110;
    localparam logic [5:0] OpWriteByte = 6'b000101;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_t;

    state_t      state_q;
    logic [7:0]  count_q;
    logic        req_load_q;
    logic [1:0]  req_size_q;
    logic        req_signed_q;

    logic [32:0] nbytes;
    logic [32:0] last_addr;
    logic        size_fault;
    logic        range_fault;
    logic        align_fault;
    logic        req_fault;
    logic [5:0]  op_sel;
    logic [31:0] load_ext;

    // Request decode, evaluated on the raw inputs while idle
    always_comb begin
        nbytes = 33'd1;
        op_sel = Load ? OpReadByte : OpWriteByte;
        case (Size)
            2'b01: begin
                nbytes = 33'd2;
                op_sel = Load ? OpReadHalf : OpWriteHalf;
            end
            2'b10: begin
                nbytes = 33'd4;
                op_sel = Load ? OpReadWord : OpWriteWord;
            end
            default: ;
        endcase
        // 33-bit sum so an access near 2^32 cannot wrap back into range
        last_addr   = {1'b0, Addr} + nbytes - 33'd1;
        size_fault  = (Size == 2'b11);
        range_fault = (last_addr >= AddrLimit);
`ifdef ALIGN_CHECK_EN
        align_fault = ((Size == 2'b01) && Addr[0]) ||
                      ((Size == 2'b10) && (Addr[1:0] != 2'b00));
`else
        align_fault = 1'b0;
`endif
        req_fault = size_fault | range_fault | align_fault;
    end

    always_comb begin
        load_ext = MemDataOut;
        case (req_size_q)
            2'b00:   load_ext = req_signed_q ? {{24{MemDataOut[7]}}, MemDataOut[7:0]}
                                             : {24'h0, MemDataOut[7:0]};
            2'b01:   load_ext = req_signed_q ? {{16{MemDataOut[15]}}, MemDataOut[15:0]}
                                             : {16'h0, MemDataOut[15:0]};
            default: load_ext = MemDataOut;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= StIdle;
            count_q      <= 8'd0;
            req_load_q   <= 1'b0;
            req_size_q   <= 2'b00;
            req_signed_q <= 1'b0;
            Busy         <= 1'b0;
            Done         <= 1'b0;
            Err          <= 1'b0;
            LoadData     <= 32'h0;
            MemEnable    <= 1'b0;
            MemReadWrite <= 1'b0;
            MemAddress   <= 32'h0;
            MemDataIn    <= 32'h0;
            MemOP        <= 6'h0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (Start) begin
                        req_load_q   <= Load;
                        req_size_q   <= Size;
                        req_signed_q <= Signed;
                        Busy         <= 1'b1;
                        if (req_fault) begin
                            state_q <= StDone;
                            Done    <= 1'b1;
                            Err     <= 1'b1;
                        end else begin
                            state_q      <= StIssue;
                            count_q      <= 8'd0;
                            MemEnable    <= 1'b1;
                            MemReadWrite <= Load;
                            MemAddress   <= Addr;
                            MemDataIn    <= StoreData;
                            MemOP        <= op_sel;
                        end
                    end
                end
                StIssue: begin
                    state_q <= StWait;
                    count_q <= 8'd0;
                end
                StWait: begin
                    if (MOC) begin
                        if (req_load_q) begin
                            LoadData <= load_ext;
                        end
                        state_q   <= StDone;
                        Done      <= 1'b1;
                        Err       <= 1'b0;
                        MemEnable <= 1'b0;
                    end else if (count_q == TimeoutCnt) begin
                        state_q   <= StDone;
                        Done      <= 1'b1;
                        Err       <= 1'b1;
                        MemEnable <= 1'b0;
                    end else begin
                        count_q <= count_q + 8'd1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    Done    <= 1'b0;
                    Err     <= 1'b0;
                    Busy    <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Table-driven bench for mem_access_ctrl with a behavioural 512x8 big-endian RAM.
// Honours ALIGN_CHECK_EN for the unaligned-half expectation.
module tb_mem_access_ctrl;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        Load = 1'b0;
    logic [1:0]  Size = 2'b00;
    logic        Signed = 1'b0;
    logic [31:0] Addr = 32'h0;
    logic [31:0] StoreData = 32'h0;
    logic        Busy, Done, Err;
    logic [31:0] LoadData;
    logic        MemEnable, MemReadWrite;
    logic [31:0] MemAddress, MemDataIn;
    logic [5:0]  MemOP;
    logic [31:0] MemDataOut = 32'h0;
    logic        MOC = 1'b0;

    int checks = 0;
    int errors = 0;
    logic hold_low = 1'b0;

    mem_access_ctrl dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Load(Load), .Size(Size),
        .Signed(Signed), .Addr(Addr), .StoreData(StoreData), .Busy(Busy),
        .Done(Done), .Err(Err), .LoadData(LoadData), .MemEnable(MemEnable),
        .MemReadWrite(MemReadWrite), .MemAddress(MemAddress), .MemDataIn(MemDataIn),
        .MemOP(MemOP), .MemDataOut(MemDataOut), .MOC(MOC)
    );

    always #5 Clk = ~Clk;

    // RAM model: responds one cycle after seeing Enable with a legal OP/ReadWrite pair
    logic [7:0] ram [0:511];
    logic [8:0] a0, a1, a2, a3;
    assign a0 = MemAddress[8:0];
    assign a1 = a0 + 9'd1;
    assign a2 = a0 + 9'd2;
    assign a3 = a0 + 9'd3;

    always @(posedge Clk) begin
        if (MemEnable && !hold_low) begin
            MOC <= 1'b1;
            case ({MemReadWrite, MemOP})
                {1'b1, 6'b000001}: MemDataOut <= {24'h0, ram[a0]};
                {1'b1, 6'b000010}: MemDataOut <= {16'h0, ram[a0], ram[a1]};
                {1'b1, 6'b001000}: MemDataOut <= {ram[a0], ram[a1], ram[a2], ram[a3]};
                {1'b0, 6'b000101}: ram[a0] <= MemDataIn[7:0];
                {1'b0, 6'b000110}: begin
                    ram[a0] <= MemDataIn[15:8];
                    ram[a1] <= MemDataIn[7:0];
                end
                {1'b0, 6'b000100}: begin
                    ram[a0] <= MemDataIn[31:24];
                    ram[a1] <= MemDataIn[23:16];
                    ram[a2] <= MemDataIn[15:8];
                    ram[a3] <= MemDataIn[7:0];
                end
                default: MOC <= 1'b0;
            endcase
        end else begin
            MOC <= 1'b0;
        end
    end

    typedef struct {
        logic        load;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic        exp_err;
        logic [31:0] exp_ld;
        int          exp_lat;
        int          exp_en;
        logic [5:0]  exp_op;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vec [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issues one request; latency is counted in cycles after the accepting edge
    task automatic run_req(input vec_t v, output int lat, output int en,
                           output logic [5:0] op, output logic en_at_done);
        lat = -1;
        en = 0;
        op = 6'h3f;
        en_at_done = 1'b1;
        @(negedge Clk);
        Load = v.load;
        Size = v.size;
        Signed = v.sgn;
        Addr = v.addr;
        StoreData = v.sdata;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        Load = ~v.load;
        Size = 2'b11;
        Signed = ~v.sgn;
        Addr = 32'h0000_01ff;
        StoreData = 32'hffff_ffff;
        for (int n = 1; n <= 40; n++) begin
            @(negedge Clk);
            if (MemEnable) begin
                if (en == 0) op = MemOP;
                en++;
            end
            if (Done) begin
                lat = n;
                en_at_done = MemEnable;
                break;
            end
        end
    endtask

    int lat, en;
    logic [5:0] op;
    logic en_done;
    vec_t tv;

    initial begin
        for (int i = 0; i < 512; i++) ram[i] = 8'h00;
        ram[0] = 8'h12; ram[1] = 8'h34; ram[2] = 8'h56; ram[3] = 8'h78;

        //            ld    sz     sg    addr           sdata          err   exp_ld         lat en op
        vec[0]  = '{1'b1, 2'b10, 1'b0, 32'd0,         32'h0,         1'b0, 32'h12345678, 3, 2, 6'h08};
        vec[1]  = '{1'b0, 2'b00, 1'b0, 32'd5,         32'h123456f0,  1'b0, 32'h12345678, 3, 2, 6'h05};
        vec[2]  = '{1'b1, 2'b00, 1'b1, 32'd5,         32'h0,         1'b0, 32'hfffffff0, 3, 2, 6'h01};
        vec[3]  = '{1'b1, 2'b00, 1'b0, 32'd5,         32'h0,         1'b0, 32'h000000f0, 3, 2, 6'h01};
        vec[4]  = '{1'b0, 2'b01, 1'b0, 32'd2,         32'h9999aabb,  1'b0, 32'h000000f0, 3, 2, 6'h06};
        vec[5]  = '{1'b1, 2'b01, 1'b0, 32'd2,         32'h0,         1'b0, 32'h0000aabb, 3, 2, 6'h02};
        vec[6]  = '{1'b1, 2'b01, 1'b1, 32'd2,         32'h0,         1'b0, 32'hffffaabb, 3, 2, 6'h02};
        vec[7]  = '{1'b1, 2'b10, 1'b0, 32'd0,         32'h0,         1'b0, 32'h1234aabb, 3, 2, 6'h08};
        vec[8]  = '{1'b1, 2'b10, 1'b0, 32'd510,       32'h0,         1'b1, 32'h1234aabb, 1, 0, 6'h00};
        vec[9]  = '{1'b1, 2'b11, 1'b0, 32'd0,         32'h0,         1'b1, 32'h1234aabb, 1, 0, 6'h00};
        vec[10] = '{1'b1, 2'b00, 1'b0, 32'd511,       32'h0,         1'b0, 32'h00000000, 3, 2, 6'h01};
        vec[11] = '{1'b1, 2'b01, 1'b0, 32'd511,       32'h0,         1'b1, 32'h00000000, 1, 0, 6'h00};
        vec[12] = '{1'b0, 2'b10, 1'b0, 32'd508,       32'hdeadbeef,  1'b0, 32'h00000000, 3, 2, 6'h04};
        vec[13] = '{1'b1, 2'b10, 1'b0, 32'd508,       32'h0,         1'b0, 32'hdeadbeef, 3, 2, 6'h08};
        vec[14] = '{1'b1, 2'b00, 1'b1, 32'd508,       32'h0,         1'b0, 32'hffffffde, 3, 2, 6'h01};
        vec[15] = '{1'b1, 2'b10, 1'b0, 32'hfffffffe,  32'h0,         1'b1, 32'hffffffde, 1, 0, 6'h00};
`ifdef ALIGN_CHECK_EN
        vec[16] = '{1'b1, 2'b01, 1'b0, 32'd1,         32'h0,         1'b1, 32'hffffffde, 1, 0, 6'h00};
`else
        vec[16] = '{1'b1, 2'b01, 1'b0, 32'd1,         32'h0,         1'b0, 32'h000034aa, 3, 2, 6'h02};
`endif
        vec[17] = '{1'b1, 2'b10, 1'b0, 32'd4,         32'h0,         1'b0, 32'h00f00000, 3, 2, 6'h08};

        // Reset state
        repeat (2) @(negedge Clk);
        check("rst_busy", {31'h0, Busy}, 32'h0);
        check("rst_done", {31'h0, Done}, 32'h0);
        check("rst_err", {31'h0, Err}, 32'h0);
        check("rst_ld", LoadData, 32'h0);
        check("rst_en", {31'h0, MemEnable}, 32'h0);
        check("rst_op", {26'h0, MemOP}, 32'h0);
        check("rst_addr", MemAddress, 32'h0);
        Reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            run_req(vec[i], lat, en, op, en_done);
            check($sformatf("v%0d_lat", i), lat, vec[i].exp_lat);
            check($sformatf("v%0d_err", i), {31'h0, Err}, {31'h0, vec[i].exp_err});
            check($sformatf("v%0d_ld", i), LoadData, vec[i].exp_ld);
            check($sformatf("v%0d_en", i), en, vec[i].exp_en);
            check($sformatf("v%0d_busy", i), {31'h0, Busy}, 32'h1);
            check($sformatf("v%0d_en_done", i), {31'h0, en_done}, 32'h0);
            if (vec[i].exp_en != 0) check($sformatf("v%0d_op", i), {26'h0, op}, {26'h0, vec[i].exp_op});
        end
        check("ram2", {24'h0, ram[2]}, 32'haa);
        check("ram3", {24'h0, ram[3]}, 32'hbb);

        // Start held through ISSUE, WAIT and DONE must not start a second access
        @(negedge Clk);
        Load = 1'b1; Size = 2'b10; Signed = 1'b0; Addr = 32'd0; Start = 1'b1;
        repeat (3) @(negedge Clk);
        check("hold_done", {31'h0, Done}, 32'h1);
        @(posedge Clk);
        #1 Start = 1'b0;
        @(negedge Clk);
        check("hold_busy", {31'h0, Busy}, 32'h0);
        check("hold_en", {31'h0, MemEnable}, 32'h0);

        // Timeout: MOC held low
        hold_low = 1'b1;
        tv = '{1'b1, 2'b10, 1'b0, 32'd0, 32'h0, 1'b1, 32'h1234aabb, 18, 17, 6'h08};
        run_req(tv, lat, en, op, en_done);
        check("to_lat", lat, 18);
        check("to_err", {31'h0, Err}, 32'h1);
        check("to_ld", LoadData, 32'h1234aabb);
        check("to_en", en, 17);
        check("to_en_done", {31'h0, en_done}, 32'h0);

        // Async reset mid-WAIT
        @(negedge Clk);
        Load = 1'b1; Size = 2'b10; Addr = 32'd0; Start = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        repeat (4) @(negedge Clk);
        check("wait_en", {31'h0, MemEnable}, 32'h1);
        #2 Reset = 1'b1;
        #1;
        check("arst_en", {31'h0, MemEnable}, 32'h0);
        check("arst_busy", {31'h0, Busy}, 32'h0);
        check("arst_ld", LoadData, 32'h0);
        @(negedge Clk);
        Reset = 1'b0;
        hold_low = 1'b0;
        tv = '{1'b1, 2'b10, 1'b0, 32'd508, 32'h0, 1'b0, 32'hdeadbeef, 3, 2, 6'h08};
        run_req(tv, lat, en, op, en_done);
        check("post_lat", lat, 3);
        check("post_err", {31'h0, Err}, 32'h0);
        check("post_ld", LoadData, 32'hdeadbeef);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
